// File: rtl/hazard_fwd_unit_if.sv
// ID-stage request and hazard/forwarding response bundle between the pipeline
// control and hazard_fwd_unit.
interface hazard_fwd_unit_if #(
  parameter int ADDR_W = 5,
  parameter int SEL_W  = 2
);
  logic              id_valid;
  logic [ADDR_W-1:0] id_rs_addr;
  logic [ADDR_W-1:0] id_rt_addr;
  logic              id_rs_used;
  logic              id_rt_used;
  logic              id_wen;
  logic [ADDR_W-1:0] id_waddr;
  logic              id_is_load;
  logic              br_taken;
  logic              stall;
  logic              flush;
  logic [SEL_W-1:0]  fwd_a_sel;
  logic [SEL_W-1:0]  fwd_b_sel;
  logic [31:0]       stall_cnt;

  modport master (
    output id_valid, id_rs_addr, id_rt_addr, id_rs_used, id_rt_used,
           id_wen, id_waddr, id_is_load, br_taken,
    input  stall, flush, fwd_a_sel, fwd_b_sel, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs_addr, id_rt_addr, id_rs_used, id_rt_used,
           id_wen, id_waddr, id_is_load, br_taken,
    output stall, flush, fwd_a_sel, fwd_b_sel, stall_cnt
  );
endinterface

// File: rtl/hazard_fwd_unit.sv
// Forwarding/interlock controller: tracks in-flight register writers in a shift
// queue and derives ID stall, branch flush and registered EXE forwarding selects.

module hfu_opnd_match #(
  parameter int ADDR_W   = 5,
  parameter int N_FWD    = 3,
  parameter int SEL_W    = 2,
  parameter int LOAD_LAT = 2
) (
  input  logic [ADDR_W-1:0]             addr,
  input  logic                          used,
  input  logic [N_FWD:1]                vld_pipe,
  input  logic [N_FWD:1]                wen_pipe,
  input  logic [N_FWD:1]                ld_pipe,
  input  logic [N_FWD:1][ADDR_W-1:0]    waddr_pipe,
  output logic [SEL_W-1:0]              sel,
  output logic                          haz
);
  // Scan oldest to youngest so the youngest matching writer has the last word.
  always_comb begin
    sel = '0;
    haz = 1'b0;
    for (int k = N_FWD; k >= 1; k--) begin
      if (vld_pipe[k] && wen_pipe[k] && (waddr_pipe[k] == addr) &&
          (addr != '0) && used) begin
        sel = SEL_W'(k);
        haz = ld_pipe[k] && (k < LOAD_LAT);
      end
    end
  end
endmodule

module hazard_fwd_unit #(
  parameter int ADDR_W   = 5,
  parameter int N_FWD    = 3,
  parameter int LOAD_LAT = 2,
  parameter int BR_DEPTH = 3,
  parameter int SEL_W    = 2
) (
  input logic              clk,
  input logic              rst_n,
  hazard_fwd_unit_if.slave hif
);
  localparam int N_OPND = 2;

  logic [N_FWD:1]             vld_pipe, wen_pipe, ld_pipe;
  logic [N_FWD:1][ADDR_W-1:0] waddr_pipe;

  logic [N_OPND-1:0][ADDR_W-1:0] op_addr;
  logic [N_OPND-1:0]             op_used, op_haz;
  logic [N_OPND-1:0][SEL_W-1:0]  op_sel;

  logic             stall, flush, xfer;
  logic [SEL_W-1:0] fwd_a_sel_q, fwd_b_sel_q;
  logic [31:0]      stall_cnt_q;

  // Operand 0 feeds EXE port A (rs), operand 1 feeds port B (rt).
  assign op_addr = {hif.id_rt_addr, hif.id_rs_addr};
  assign op_used = {hif.id_rt_used, hif.id_rs_used};

  for (genvar i = 0; i < N_OPND; i++) begin : g_opnd
    hfu_opnd_match #(
      .ADDR_W(ADDR_W), .N_FWD(N_FWD), .SEL_W(SEL_W), .LOAD_LAT(LOAD_LAT)
    ) u_match (
      .addr      (op_addr[i]),
      .used      (op_used[i]),
      .vld_pipe  (vld_pipe),
      .wen_pipe  (wen_pipe),
      .ld_pipe   (ld_pipe),
      .waddr_pipe(waddr_pipe),
      .sel       (op_sel[i]),
      .haz       (op_haz[i])
    );
  end

  assign flush = hif.br_taken;
  assign stall = hif.id_valid & (|op_haz) & ~flush;
  assign xfer  = hif.id_valid & ~stall & ~flush;

  // Stalled or flushed cycles push a bubble; a flush also kills writers younger
  // than the resolving branch while older ones keep draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe   <= '0;
      wen_pipe   <= '0;
      ld_pipe    <= '0;
      waddr_pipe <= '0;
    end else begin
      vld_pipe[1]   <= xfer;
      wen_pipe[1]   <= hif.id_wen;
      ld_pipe[1]    <= hif.id_is_load;
      waddr_pipe[1] <= hif.id_waddr;
      for (int k = 2; k <= N_FWD; k++) begin
        vld_pipe[k]   <= vld_pipe[k-1] & ~(flush && ((k - 1) < BR_DEPTH));
        wen_pipe[k]   <= wen_pipe[k-1];
        ld_pipe[k]    <= ld_pipe[k-1];
        waddr_pipe[k] <= waddr_pipe[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a_sel_q <= '0;
      fwd_b_sel_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fwd_a_sel_q <= xfer ? op_sel[0] : '0;
      fwd_b_sel_q <= xfer ? op_sel[1] : '0;
      if (stall && (stall_cnt_q != 32'hFFFF_FFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign hif.stall     = stall;
  assign hif.flush     = flush;
  assign hif.fwd_a_sel = fwd_a_sel_q;
  assign hif.fwd_b_sel = fwd_b_sel_q;
  assign hif.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench: DUT A uses LOAD_LAT=2, DUT B uses LOAD_LAT=3 for the
// multi-cycle stall and mid-stall reset cases.
module tb_hazard_fwd_unit;
  logic clk;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  hazard_fwd_unit_if #(.ADDR_W(5), .SEL_W(2)) ia ();
  hazard_fwd_unit_if #(.ADDR_W(5), .SEL_W(2)) ib ();

  hazard_fwd_unit #(.ADDR_W(5), .N_FWD(3), .LOAD_LAT(2), .BR_DEPTH(3), .SEL_W(2))
    u_dut_a (.clk(clk), .rst_n(rst_n), .hif(ia.slave));
  hazard_fwd_unit #(.ADDR_W(5), .N_FWD(3), .LOAD_LAT(3), .BR_DEPTH(3), .SEL_W(2))
    u_dut_b (.clk(clk), .rst_n(rst_n), .hif(ib.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic v, input logic [4:0] rs, input logic rsu,
                       input logic [4:0] rt, input logic rtu, input logic wen,
                       input logic [4:0] wa, input logic ld);
    ia.id_valid = v;   ia.id_rs_addr = rs; ia.id_rs_used = rsu;
    ia.id_rt_addr = rt; ia.id_rt_used = rtu; ia.id_wen = wen;
    ia.id_waddr = wa;  ia.id_is_load = ld;
  endtask

  task automatic set_b(input logic v, input logic [4:0] rs, input logic rsu,
                       input logic [4:0] rt, input logic rtu, input logic wen,
                       input logic [4:0] wa, input logic ld);
    ib.id_valid = v;   ib.id_rs_addr = rs; ib.id_rs_used = rsu;
    ib.id_rt_addr = rt; ib.id_rt_used = rtu; ib.id_wen = wen;
    ib.id_waddr = wa;  ib.id_is_load = ld;
  endtask

  initial begin
    rst_n = 1'b0;
    set_a(0, 0, 0, 0, 0, 0, 0, 0);
    set_b(0, 0, 0, 0, 0, 0, 0, 0);
    ia.br_taken = 1'b0;
    ib.br_taken = 1'b0;
    #1;
    chk("rst_stall", ia.stall, 0);
    chk("rst_flush", ia.flush, 0);
    chk("rst_sel_a", ia.fwd_a_sel, 0);
    chk("rst_sel_b", ia.fwd_b_sel, 0);
    chk("rst_cnt", ia.stall_cnt, 0);
    tick(); tick();
    rst_n = 1'b1;

    // 1: ALU producer then back-to-back consumer
    set_a(1, 1, 1, 2, 1, 1, 3, 0);
    #1 chk("t1_prod_stall", ia.stall, 0);
    tick();
    chk("t1_prod_sel_a", ia.fwd_a_sel, 0);
    set_a(1, 3, 1, 3, 1, 1, 4, 0);
    #1 chk("t1_cons_stall", ia.stall, 0);
    tick();
    chk("t1_sel_a", ia.fwd_a_sel, 1);
    chk("t1_sel_b", ia.fwd_b_sel, 1);
    set_a(0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick(); tick();
    chk("t1_idle_sel", ia.fwd_a_sel, 0);

    // 2: load-use, one-cycle interlock
    set_a(1, 29, 1, 5, 0, 1, 5, 1);
    tick();
    set_a(1, 5, 1, 0, 1, 1, 6, 0);
    #1 chk("t2_stall1", ia.stall, 1);
    chk("t2_flush", ia.flush, 0);
    tick();
    chk("t2_bubble_a", ia.fwd_a_sel, 0);
    chk("t2_bubble_b", ia.fwd_b_sel, 0);
    chk("t2_cnt1", ia.stall_cnt, 1);
    #1 chk("t2_stall2", ia.stall, 0);
    tick();
    chk("t2_sel_a", ia.fwd_a_sel, 2);
    chk("t2_sel_b", ia.fwd_b_sel, 0);
    chk("t2_cnt_final", ia.stall_cnt, 1);
    set_a(0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick(); tick();

    // 3: youngest writer wins over an older load
    set_a(1, 29, 1, 7, 0, 1, 7, 1);
    tick();
    set_a(1, 1, 1, 2, 1, 1, 7, 0);
    tick();
    set_a(1, 7, 1, 7, 1, 1, 8, 0);
    #1 chk("t3_stall", ia.stall, 0);
    tick();
    chk("t3_sel_a", ia.fwd_a_sel, 1);
    chk("t3_sel_b", ia.fwd_b_sel, 1);
    set_a(0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick(); tick();

    // 4: r0 is never forwarded, even from a load
    set_a(1, 29, 1, 0, 0, 1, 0, 1);
    tick();
    set_a(1, 0, 1, 0, 1, 1, 9, 0);
    #1 chk("t4_stall", ia.stall, 0);
    tick();
    chk("t4_sel_a", ia.fwd_a_sel, 0);
    chk("t4_sel_b", ia.fwd_b_sel, 0);
    set_a(0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick(); tick();

    // 5: flush overrides a pending load-use stall and kills the load
    set_a(1, 29, 1, 9, 0, 1, 9, 1);
    tick();
    set_a(1, 9, 1, 9, 1, 1, 10, 0);
    ia.br_taken = 1'b1;
    #1 chk("t5_stall", ia.stall, 0);
    chk("t5_flush", ia.flush, 1);
    tick();
    chk("t5_sel_a", ia.fwd_a_sel, 0);
    chk("t5_cnt", ia.stall_cnt, 1);
    ia.br_taken = 1'b0;
    #1 chk("t5_flush_off", ia.flush, 0);
    chk("t5_post_stall", ia.stall, 0);
    tick();
    chk("t5_post_sel_a", ia.fwd_a_sel, 0);
    chk("t5_post_sel_b", ia.fwd_b_sel, 0);
    set_a(0, 0, 0, 0, 0, 0, 0, 0);

    // LOAD_LAT=3: match at k=1 stalls for two cycles
    set_b(1, 29, 1, 5, 0, 1, 5, 1);
    #1 chk("b_ld_stall", ib.stall, 0);
    tick();
    set_b(1, 5, 1, 0, 0, 1, 6, 0);
    #1 chk("b_stall_k1", ib.stall, 1);
    tick();
    #1 chk("b_stall_k2", ib.stall, 1);
    chk("b_bubble_a", ib.fwd_a_sel, 0);
    tick();
    #1 chk("b_stall_k3", ib.stall, 0);
    chk("b_cnt2", ib.stall_cnt, 2);
    tick();
    chk("b_sel_a3", ib.fwd_a_sel, 3);
    set_b(0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick(); tick();

    // 6: asynchronous reset in the middle of a stall
    set_b(1, 29, 1, 5, 0, 1, 5, 1);
    tick();
    set_b(1, 5, 1, 0, 0, 1, 6, 0);
    #1 chk("t6_stall1", ib.stall, 1);
    tick();
    #1 chk("t6_stall2", ib.stall, 1);
    chk("t6_cnt3", ib.stall_cnt, 3);
    #1 rst_n = 1'b0;
    #1 chk("t6_rst_stall", ib.stall, 0);
    chk("t6_rst_sel_a", ib.fwd_a_sel, 0);
    chk("t6_rst_cnt", ib.stall_cnt, 0);
    tick();
    rst_n = 1'b1;
    #1 chk("t6_rel_stall", ib.stall, 0);
    tick();
    chk("t6_rel_sel_a", ib.fwd_a_sel, 0);
    chk("t6_rel_cnt", ib.stall_cnt, 0);
    set_b(0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
